// File: rtl/linear_interpolator.sv
// Linear interpolating upsampler. Each accepted input interval produces FACTOR
// output samples that ramp linearly from the previous input toward the current one.
//
// Ports:
//   clk       clock
//   nrst      synchronous active-low reset (takes priority over ena)
//   ena       global enable; when low all state and outputs hold
//   id        input sample (unsigned, DATA_W bits)
//   id_valid  input sample valid
//   id_ready  block can accept id this cycle (combinational)
//   od        interpolated output sample (registered)
//   od_valid  od valid (registered)
//   od_ready  downstream accepts od
module linear_interpolator #(
  parameter int unsigned FACTOR   = 8,
  parameter int unsigned FACTOR_W = $clog2(FACTOR),
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ena,
  input  logic [DATA_W-1:0] id,
  input  logic              id_valid,
  output logic              id_ready,
  output logic [DATA_W-1:0] od,
  output logic              od_valid,
  input  logic              od_ready
);

  // One spare bit above DATA_W+FACTOR_W so acc can take a signed step.
  localparam int unsigned AccW = DATA_W + FACTOR_W + 1;
  localparam int unsigned ExtW = AccW - DATA_W - 1;
  localparam logic [AccW-1:0]     FactorC = AccW'(FACTOR);
  localparam logic [FACTOR_W-1:0] KLast   = FACTOR_W'(FACTOR - 1);

  typedef enum logic [1:0] {StFill, StWait, StRamp} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic [DATA_W:0]     delta_q, delta_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [FACTOR_W-1:0] k_q, k_d;
  logic [DATA_W-1:0]   od_q, od_d;
  logic                od_valid_q, od_valid_d;

  logic in_hs, out_hs, last_hs;
  logic [AccW-1:0] delta_ext;

  assign out_hs    = od_valid_q & od_ready & ena;
  assign last_hs   = (state_q == StRamp) & (k_q == KLast) & out_hs;
  assign id_ready  = (state_q != StRamp) | last_hs;
  assign in_hs     = id_valid & id_ready & ena;
  // Two's-complement step: acc stays non-negative, so plain modular add is exact.
  assign delta_ext = {{ExtW{delta_q[DATA_W]}}, delta_q};

  assign od       = od_q;
  assign od_valid = od_valid_q;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    delta_d    = delta_q;
    acc_d      = acc_q;
    k_d        = k_q;
    od_d       = od_q;
    od_valid_d = od_valid_q;

    unique case (state_q)
      StFill: begin
        if (in_hs) begin
          prev_d  = id;
          state_d = StWait;
        end
      end
      StWait: begin
        if (in_hs) begin
          cur_d      = id;
          delta_d    = {1'b0, id} - {1'b0, prev_q};
          acc_d      = AccW'(prev_q) * FactorC;
          k_d        = '0;
          od_d       = prev_q;
          od_valid_d = 1'b1;
          state_d    = StRamp;
        end
      end
      StRamp: begin
        if (last_hs) begin
          prev_d = cur_q;
          if (in_hs) begin
            // Back-to-back ramp: the old target is the new ramp's first output.
            cur_d   = id;
            delta_d = {1'b0, id} - {1'b0, cur_q};
            acc_d   = AccW'(cur_q) * FactorC;
            k_d     = '0;
            od_d    = cur_q;
          end else begin
            od_valid_d = 1'b0;
            state_d    = StWait;
          end
        end else if (out_hs) begin
          k_d   = k_q + 1'b1;
          acc_d = acc_q + delta_ext;
          od_d  = DATA_W'(acc_d / FactorC);
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= StFill;
      prev_q     <= '0;
      cur_q      <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      od_q       <= '0;
      od_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      delta_q    <= delta_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      od_q       <= od_d;
      od_valid_q <= od_valid_d;
    end
  end

endmodule

// File: tb/tb_linear_interpolator.sv
// Self-checking bench for linear_interpolator: two instances (FACTOR=4 and
// FACTOR=3, DATA_W=8) checked against a queue-based reference of expected outputs.
module tb_linear_interpolator;

  logic       clk = 1'b0;
  logic       nrst;
  logic       ena;
  logic [7:0] id [2];
  logic       id_valid [2];
  logic       id_ready [2];
  logic [7:0] od [2];
  logic       od_valid [2];
  logic       od_ready [2];

  int total = 0;
  int bad = 0;
  int q[$];
  int prev_m = 0;
  bit primed = 1'b0;
  int sel = 0;
  int last_pop = -1;

  always #5 clk = ~clk;

  linear_interpolator #(.FACTOR(4), .FACTOR_W(2), .DATA_W(8)) u_dut4 (
    .clk(clk), .nrst(nrst), .ena(ena),
    .id(id[0]), .id_valid(id_valid[0]), .id_ready(id_ready[0]),
    .od(od[0]), .od_valid(od_valid[0]), .od_ready(od_ready[0])
  );

  linear_interpolator #(.FACTOR(3), .FACTOR_W(2), .DATA_W(8)) u_dut3 (
    .clk(clk), .nrst(nrst), .ena(ena),
    .id(id[1]), .id_valid(id_valid[1]), .id_ready(id_ready[1]),
    .od(od[1]), .od_valid(od_valid[1]), .od_ready(od_ready[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each accepted sample after the first yields f points on the
  // straight line from the previous sample, truncated.
  task automatic model_accept(input int x, input int f);
    if (!primed) begin
      primed = 1'b1;
    end else begin
      for (int k = 0; k < f; k++) q.push_back((prev_m * f + k * (x - prev_m)) / f);
    end
    prev_m = x;
  endtask

  task automatic cycle(input bit iv, input logic [7:0] x, input bit ordy, input bit en,
                       output bit took);
    int n;
    bit hs_out;
    bit hs_in;
    int f;
    id[sel]       = x;
    id_valid[sel] = iv;
    od_ready[sel] = ordy;
    ena           = en;
    @(negedge clk);
    f      = (sel == 0) ? 4 : 3;
    n      = q.size();
    hs_out = od_valid[sel] && ordy && en;
    hs_in  = iv && id_ready[sel] && en;
    chk("od_valid", 32'(od_valid[sel]), 32'(n != 0));
    chk("id_ready", 32'(id_ready[sel]), 32'((n == 0) || (n == 1 && hs_out)));
    if (n != 0) chk("od", 32'(od[sel]), q[0]);
    if (hs_out && n != 0) last_pop = q.pop_front();
    if (hs_in) model_accept(int'(x), f);
    took = hs_in;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input bit rnd_ready);
    bit took = 1'b0;
    for (int i = 0; i < 50 && !took; i++) cycle(1'b1, x, rnd_ready ? 1'($urandom) : 1'b1, 1'b1, took);
    if (!took) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input bit rnd_ready);
    bit took;
    for (int i = 0; i < 200 && q.size() != 0; i++)
      cycle(1'b0, 8'd0, rnd_ready ? 1'($urandom) : 1'b1, 1'b1, took);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Reset is applied with ena low to show it takes priority.
  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      id_valid[d] = 1'b0;
      od_ready[d] = 1'b0;
      id[d]       = 8'd0;
    end
    ena  = 1'b0;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    ena  = 1'b1;
    q.delete();
    primed = 1'b0;
    prev_m = 0;
    chk("rst_od", 32'(od[sel]), 32'd0);
    chk("rst_od_valid", 32'(od_valid[sel]), 32'd0);
    chk("rst_id_ready", 32'(id_ready[sel]), 32'd1);
  endtask

  initial begin
    bit took;
    nrst = 1'b0;
    ena  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      id_valid[d] = 1'b0;
      od_ready[d] = 1'b0;
      id[d]       = 8'd0;
    end

    // FACTOR=4 directed ramps
    sel = 0;
    do_reset();
    send(8'd0, 1'b0);
    send(8'd100, 1'b0);
    drain(1'b0);
    send(8'd0, 1'b0);
    drain(1'b0);
    do_reset();
    send(8'd255, 1'b0);
    send(8'd0, 1'b0);
    drain(1'b0);

    // Continuous full-throughput stream
    for (int i = 0; i < 12; i++) send(8'($urandom), 1'b0);
    drain(1'b0);

    // Backpressure
    do_reset();
    send(8'd0, 1'b1);
    send(8'd100, 1'b1);
    drain(1'b1);

    // ena low mid-ramp
    do_reset();
    send(8'd0, 1'b0);
    send(8'd100, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b1, took);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'd77, 1'b1, 1'b0, took);
    drain(1'b0);

    // Reset mid-ramp, then re-prime
    do_reset();
    send(8'd0, 1'b0);
    send(8'd100, 1'b0);
    last_pop = -1;
    for (int i = 0; i < 20 && last_pop != 50; i++) cycle(1'b0, 8'd0, 1'b1, 1'b1, took);
    chk("saw_50", 32'(last_pop), 32'd50);
    do_reset();
    send(8'd200, 1'b0);
    send(8'd100, 1'b0);
    drain(1'b0);

    // Random mix of valid, ready and enable
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 8'($urandom), ($urandom % 4) != 0, ($urandom % 8) != 0, took);
    drain(1'b0);

    // FACTOR=3
    sel = 1;
    do_reset();
    send(8'd0, 1'b0);
    send(8'd10, 1'b0);
    send(8'd10, 1'b0);
    drain(1'b0);
    for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0);
    drain(1'b0);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 8'($urandom), ($urandom % 4) != 0, ($urandom % 8) != 0, took);
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linear_interpolator.md
Name: linear_interpolator

Overview:
- Upsampling counterpart to the moving-average block: takes a low-rate unsigned sample stream and emits FACTOR output samples per input interval.
- Output samples ramp linearly from the previous input toward the current one.
- Sits on the expansion side of a rate-change path; both ports use valid/ready handshakes, plus a global clock enable.

Parameters:
FACTOR, 8, interpolation ratio (outputs per input), >=2, need not be a power of two (2^N is cheapest)
FACTOR_W, $clog2(FACTOR), ramp counter / accumulator growth width
DATA_W, 16, sample width, unsigned

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
ena  in  1  global enable; when 0 all state and outputs hold
id  in  DATA_W  input sample
id_valid  in  1  input sample valid
id_ready  out  1  block can accept id this cycle
od  out  DATA_W  interpolated output sample, registered
od_valid  out  1  od valid, registered
od_ready  in  1  downstream accepts od

Behaviour:
- Reset (nrst=0 at posedge): state=FILL, prev=0, k=0, acc=0, od=0, od_valid=0; overrides ena. Reset mid-ramp discards prev and any pending outputs; the next accepted sample only re-primes.
- Input handshake: accept when id_valid & id_ready & ena at posedge. Output handshake: od_valid & od_ready & ena.
- States:
  - FILL: no previous sample. id_ready=1. An accept stores prev<=id, emits nothing, goes to WAIT.
  - WAIT: id_ready=1, od_valid=0. An accept of sample x sets:
    - cur<=x
    - delta<=x-prev (signed, DATA_W+1 bits)
    - acc<=prev*FACTOR (unsigned)
    - k<=0
    - goes to RAMP; od_valid rises the next cycle (1-cycle latency).
  - RAMP: presents output k with od=acc/FACTOR, i.e. od_k = (prev*FACTOR + k*delta)/FACTOR, truncating, for k=0..FACTOR-1.
    - On each output handshake: k<=k+1, acc<=acc+delta.
    - od/od_valid hold stable while od_ready=0.
- Last output (k=FACTOR-1) handshake:
  - prev<=cur.
  - id_ready=1 combinationally this cycle: id_ready = (state!=RAMP) | (k==FACTOR-1 & od_valid & od_ready & ena).
  - If a new sample is accepted in that same cycle, the next ramp starts immediately (od_valid stays 1, k=0, acc=cur*FACTOR, delta=new-cur). Full throughput: one input per FACTOR output cycles.
  - Otherwise: od_valid<=0, go to WAIT.
- Arithmetic:
  - acc is DATA_W+FACTOR_W+1 bits, signed adder. It is always in [0,(2^DATA_W-1)*FACTOR], so truncating division is unambiguous and od never overflows.
  - Division by FACTOR is a shift when FACTOR is a power of two.
  - od_0 == prev exactly. The final target value is emitted as od_0 of the next ramp.
- ena=0: no state change, handshakes ignored, outputs hold; id_ready may still be 1, but no transfer occurs.
- Equal consecutive samples (delta=0): FACTOR copies of the value.
- id_ready is never 1 in RAMP except on the final-output handshake cycle.

Test Plan:
- FACTOR=4, DATA_W=8, od_ready=1: inputs 0,100 -> od 0,25,50,75; id_ready=0 during the ramp except the cycle of the 75 handshake.
- FACTOR=4: inputs 100,0 -> od 100,75,50,25. Inputs 255,0 -> 255,191,127,63; no wrap.
- FACTOR=3: inputs 0,10,10 -> od 0,3,6 then 10,10,10; continuous stream gives back-to-back ramps with no od_valid gap.
- Backpressure: toggle od_ready 0/1 pseudo-randomly during 0->100 at FACTOR=4 -> same sequence 0,25,50,75, od stable while od_ready=0, no drops or duplicates.
- ena=0 for 5 cycles mid-ramp -> od, od_valid, k frozen; sequence resumes unchanged after ena=1.
- nrst=0 after od=50 of 0->100 -> od=0, od_valid=0 next cycle; then inputs 200,100 -> first output 200 (FILL re-primed), no residual from the old ramp.
